// File: rtl/fir_tap_sequencer_if.sv
// fir_tap_sequencer_if: sample-in, sample-out and shared-adder signals of the FIR tap sequencer
interface fir_tap_sequencer_if #(parameter int DW = 16);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [DW-1:0] add_a;
  logic [DW-1:0] add_b;
  logic [DW-1:0] add_sum;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;
  modport master (
    input  in_valid, in_data, add_sum, out_ready,
    output in_ready, add_a, add_b, out_valid, out_data, busy
  );
  modport slave (
    output in_valid, in_data, add_sum, out_ready,
    input  in_ready, add_a, add_b, out_valid, out_data, busy
  );
endinterface

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: 5-tap shift-coefficient FIR driving one shared adder a tap per cycle
module bk_add #(parameter int W = 12) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);
  logic [W-1:0] p;
  logic [W-2:0] gg, pg;
  // Brent-Kung prefix tree: up-sweep builds power-of-two spans, down-sweep fills the gaps
  always_comb begin
    p = a ^ b;
    gg = a[W-2:0] & b[W-2:0];
    pg = p[W-2:0];
    gg[0] = gg[0] | (pg[0] & cin);
    for (int s = 1; s < W - 1; s = s * 2)
      for (int i = 2 * s - 1; i < W - 1; i = i + 2 * s) begin
        gg[i] = gg[i] | (pg[i] & gg[i-s]);
        pg[i] = pg[i] & pg[i-s];
      end
    for (int s = 1 << $clog2(W); s > 0; s = s / 2)
      for (int i = 3 * s - 1; i < W - 1; i = i + 2 * s) begin
        gg[i] = gg[i] | (pg[i] & gg[i-s]);
        pg[i] = pg[i] & pg[i-s];
      end
    sum = p ^ {gg, cin};
  end
endmodule

module Brent_Kung_Approx #(parameter int DW = 16, parameter int APX = 4) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] sum
);
  logic [DW-APX-1:0] hi;
  // low bits are OR-ed; only their top bit pair forwards a carry into the exact upper adder
  bk_add #(.W(DW - APX)) u_hi (
    .a(a[DW-1:APX]),
    .b(b[DW-1:APX]),
    .cin(a[APX-1] & b[APX-1]),
    .sum(hi)
  );
  assign sum = {hi, a[APX-1:0] | b[APX-1:0]};
endmodule

module fir_tap_sequencer #(
  parameter int DW  = 16,
  parameter int SH0 = 5,
  parameter int SH1 = 4,
  parameter int SH2 = 3,
  parameter int SH3 = 2,
  parameter int SH4 = 1
) (
  input logic clk,
  input logic rst,
  fir_tap_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t        state;
  logic [DW-1:0] acc, tap, nxt_tap;
  logic [2:0]    k;
  logic [DW-1:0] d [5];
  assign bus.add_a = acc;
  assign bus.add_b = tap;
  // operand B for the following ACC cycle, indexed by the tap currently being added
  always_comb nxt_tap = k == 3'd1 ? d[2] >> SH2 : k == 3'd2 ? d[3] >> SH3 : d[4] >> SH4;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      tap <= '0;
      k <= '0;
      bus.in_ready <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.busy <= 1'b0;
      for (int i = 0; i < 5; i++) d[i] <= '0;
    end else
      case (state)
        IDLE:
          if (bus.in_valid) begin
            d[0] <= bus.in_data;
            for (int i = 1; i < 5; i++) d[i] <= d[i-1];
            acc <= bus.in_data >> SH0;
            tap <= d[0] >> SH1;
            k <= 3'd1;
            bus.in_ready <= 1'b0;
            bus.busy <= 1'b1;
            state <= ACC;
          end
        ACC: begin
          k <= k + 3'd1;
          if (k == 3'd4) begin
            bus.out_data <= bus.add_sum;
            bus.out_valid <= 1'b1;
            acc <= '0;
            tap <= '0;
            state <= DONE;
          end else begin
            acc <= bus.add_sum;
            tap <= nxt_tap;
          end
        end
        DONE:
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.busy <= 1'b0;
            bus.in_ready <= 1'b1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule
